// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes an RV32 instruction into ALU operands and
// operation code, and hands it to execute through a valid/ready interface
// backed by an output register plus one skid register.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [3:0]      out_alu_op,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1100,
    ALU_SRL  = 4'b1101,
    ALU_SRA  = 4'b1110
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] pc;
    alu_op_e         op;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
  entry_t          dec;

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign alt    = in_instr[30];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign shamt  = {27'b0, in_instr[24:20]};

  // Decode the incoming instruction into operands and ALU operation.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.op      = ALU_ADD;
    dec.illegal = 1'b0;
    unique case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec.op1 = in_rs1_data;
        dec.op2 = (opcode == OPC_OP) ? in_rs2_data : imm_i;
        unique case (funct3)
          3'b000: dec.op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
          3'b111: dec.op = ALU_AND;
          3'b110: dec.op = ALU_OR;
          3'b011: dec.op = ALU_SLTU;
          3'b001: dec.op = ALU_SLL;
          3'b101: dec.op = alt ? ALU_SRA : ALU_SRL;
          default: dec.illegal = 1'b1;
        endcase
        if (opcode == OPC_OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101))
          dec.op2 = shamt;
      end
      OPC_LOAD: begin
        dec.op1 = in_rs1_data;
        dec.op2 = imm_i;
      end
      OPC_STORE: begin
        dec.op1 = in_rs1_data;
        dec.op2 = imm_s;
      end
      OPC_BRANCH: begin
        dec.op  = ALU_SUB;
        dec.op1 = in_rs1_data;
        dec.op2 = in_rs2_data;
        if (funct3[2:1] != 2'b00) dec.illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.op2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.op1 = in_pc;
        dec.op2 = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        dec.op1 = in_pc;
        dec.op2 = XLEN'(4);
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.op  = ALU_AND;
      dec.op1 = '0;
      dec.op2 = '0;
    end
  end

  // Output/skid buffer next state: skid refills the output before new input,
  // and new input only lands in the skid while the output is stalled.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_op1     = out_q.op1;
  assign out_op2     = out_q.op2;
  assign out_alu_op  = out_q.op;
  assign out_illegal = out_q.illegal;
  assign out_pc      = out_q.pc;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage that produces the operand and operation interface consumed by the datapath ALU. It accepts a fetched instruction with its PC and register-file read data, decodes opcode/funct3/funct7 into the 4-bit ALU operation code, and selects both operands. It presents the result to the execute side through a valid/ready handshake with a two-entry skid buffer. Its role is to split the single-cycle decode→ALU path into a pipelined producer/consumer pair.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; equals "skid entry empty".
- in_instr  in  32  RV32 instruction word.
- in_pc  in  32  PC of in_instr.
- in_rs1_data / in_rs2_data  in  32 each  register-file read data.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute side accepts.
- out_op1 / out_op2  out  32 each  ALU operands.
- out_alu_op  out  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 set-less-than (unsigned), 1100 SLL, 1101 SRL, 1110 SRA.
- out_illegal  out  1  instruction not executable on this ALU.
- out_pc  out  32  PC passed through.

## Operation
- Field positions: opcode = instr[6:0], funct3 = instr[14:12], alt = instr[30].
- Immediates:
  - I: sign-extended instr[31:20].
  - S: sign-extended {instr[31:25], instr[11:7]}.
  - U: {instr[31:12], 12'b0}.
- OP (0110011): op1 = rs1, op2 = rs2.
  - f3 000: alt ? SUB : ADD.
  - f3 111: AND. f3 110: OR. f3 011: 0111.
  - f3 001: SLL. f3 101: alt ? SRA : SRL.
  - f3 010 (SLT) and f3 100 (XOR): illegal.
- OP-IMM (0010011): op1 = rs1, op2 = I-imm.
  - f3 000: ADD. Other f3 values decode as for OP, with alt ignored except on f3 101.
  - Shifts (f3 001/101): op2 = {27'b0, instr[24:20]}.
- LOAD (0000011): ADD, op1 = rs1, op2 = I-imm.
- STORE (0100011): ADD, op1 = rs1, op2 = S-imm.
- BRANCH (1100011):
  - f3 000/001: SUB, op1 = rs1, op2 = rs2.
  - Other f3 values: illegal.
- LUI (0110111): ADD, op1 = 0, op2 = U-imm.
- AUIPC (0010111): ADD, op1 = pc, op2 = U-imm.
- JAL (1101111) / JALR (1100111): ADD, op1 = pc, op2 = 4 (link value).
- Any other opcode, or an illegal case above: out_illegal = 1, alu_op = 0000, op1 = op2 = 0. The entry still flows through the handshake.
- Buffering: one output register plus one skid register, strictly FIFO order, no entry dropped or duplicated.

## Timing
- Reset (async, immediate):
  - out_valid = 0, skid empty, in_ready = 1.
  - out_op1 = out_op2 = out_pc = 0, out_alu_op = 0000, out_illegal = 0.
- Accept when in_valid && in_ready. Latency is 1 cycle: the decoded entry is on out_* at the next edge, provided the output register is empty or draining (out_valid && out_ready) in the accept cycle.
- If the output is stalled (out_valid && !out_ready) in the accept cycle, the entry goes to the skid register and in_ready falls next cycle.
- When the output drains with the skid occupied, the skid moves to the output and in_ready rises next cycle.
- Simultaneous accept and drain with an empty skid: the new entry goes directly to the output; out_valid stays 1; throughput is 1 per cycle.
- out_* are stable while out_valid && !out_ready.
- flush: both entries are cleared at the edge, and any same-cycle accept is discarded. The cycle after, out_valid = 0 and in_ready = 1.
- rst asserted mid-stream clears everything asynchronously; no entry survives.

## Test plan
- Reset: assert rst mid-transfer → out_valid = 0, in_ready = 1, out_alu_op = 0000 immediately, before the next edge.
- ADD/SUB: instr 0x002081B3 with rs1 = 5, rs2 = 7 → next cycle op1 = 5, op2 = 7, alu_op = 0010. Then 0x402081B3 → alu_op = 0110.
- SRAI/immediates: 0x40315093 → op2 = 3, alu_op = 1110. LUI 0x123450B7 → op1 = 0, op2 = 0x12345000, ADD. JAL at pc 0x100 → op1 = 0x100, op2 = 4.
- Backpressure: out_ready = 0, present three back-to-back instrs → two accepted, in_ready low, third held. Raise out_ready → three outputs in order on consecutive cycles.
- Flush: with both entries full, pulse flush while in_valid = 1 → next cycle out_valid = 0, in_ready = 1, nothing emitted.
- Illegal: XOR 0x0020C1B3, and opcode 0x7F → out_illegal = 1, alu_op = 0000, op1 = op2 = 0, handshake completes normally.
